// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter folding the fetch read port and the memory read/write
// port onto one downstream master, with a per-transaction completion timeout.
//
// Ports:
//   ACLK, ARESET                       clock, synchronous active-high reset
//   IfRead{Req,Addr} / IfRead{Data,Done}  fetch read request and result
//   MemRead*, MemWrite*                memory-stage read/write request/result
//   Read*Out, Write*Out                downstream master request outputs
//   ReadDataIn, ReadDataReady,
//   WriteDataOver                      downstream data and completion strobes
//   Busy, Timeout                      transaction outstanding, abort pulse
module axi_lite_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              IfReadReq,
  input  logic [ADDR_W-1:0] IfReadAddr,
  output logic [DATA_W-1:0] IfReadData,
  output logic              IfReadDone,
  input  logic              MemReadReq,
  input  logic [ADDR_W-1:0] MemReadAddr,
  input  logic              MemWriteReq,
  input  logic [ADDR_W-1:0] MemWriteAddr,
  input  logic [DATA_W-1:0] MemWriteData,
  input  logic [3:0]        MemWriteMask,
  output logic [DATA_W-1:0] MemReadData,
  output logic              MemReadDone,
  output logic              MemWriteDone,
  output logic              ReadEnableOut,
  output logic [ADDR_W-1:0] ReadAddrOut,
  output logic              WriteEnableOut,
  output logic [ADDR_W-1:0] WriteAddrOut,
  output logic [DATA_W-1:0] WriteDataOut,
  output logic [3:0]        WriteMaskOut,
  input  logic [DATA_W-1:0] ReadDataIn,
  input  logic              ReadDataReady,
  input  logic              WriteDataOver,
  output logic              Busy,
  output logic              Timeout
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    IF_RD  = 4'b0010,
    MEM_RD = 4'b0100,
    MEM_WR = 4'b1000
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t state_q, state_d;

  logic              last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [DATA_W-1:0] ifdat_q, ifdat_d;
  logic [DATA_W-1:0] mdat_q, mdat_d;
  logic              ifdn_q, ifdn_d;
  logic              mrdn_q, mrdn_d;
  logic              mwdn_q, mwdn_d;
  logic              tmo_q, tmo_d;

  logic mem_req;
  logic grant_if;
  logic grant_mem;
  logic expired;

  assign mem_req = MemReadReq | MemWriteReq;

  // LastGrant = 1 means MEM went last, so IF wins a tie.
  assign grant_if  = IfReadReq & (~mem_req | last_q);
  assign grant_mem = mem_req & (~IfReadReq | ~last_q);

  assign expired = (cnt_q == TMO);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    ifdat_d = ifdat_q;
    mdat_d  = mdat_q;
    ifdn_d  = 1'b0;
    mrdn_d  = 1'b0;
    mwdn_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d = IF_RD;
          last_d  = 1'b0;
          cnt_d   = '0;
          raddr_d = IfReadAddr;
          ren_d   = 1'b1;
        end else if (grant_mem) begin
          last_d = 1'b1;
          cnt_d  = '0;
          if (MemWriteReq) begin
            state_d = MEM_WR;
            waddr_d = MemWriteAddr;
            wdata_d = MemWriteData;
            wmask_d = MemWriteMask;
            wen_d   = 1'b1;
          end else begin
            state_d = MEM_RD;
            raddr_d = MemReadAddr;
            ren_d   = 1'b1;
          end
        end
      end
      IF_RD: begin
        cnt_d = cnt_q + 8'd1;
        if (ReadDataReady) begin
          state_d = IDLE;
          ifdat_d = ReadDataIn;
          ifdn_d  = 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          ifdat_d = '0;
          ifdn_d  = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      MEM_RD: begin
        cnt_d = cnt_q + 8'd1;
        if (ReadDataReady) begin
          state_d = IDLE;
          mdat_d  = ReadDataIn;
          mrdn_d  = 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          mdat_d  = '0;
          mrdn_d  = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      MEM_WR: begin
        cnt_d = cnt_q + 8'd1;
        if (WriteDataOver) begin
          state_d = IDLE;
          mwdn_d  = 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          mwdn_d  = 1'b1;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      ifdat_q <= '0;
      mdat_q  <= '0;
      ifdn_q  <= 1'b0;
      mrdn_q  <= 1'b0;
      mwdn_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      ifdat_q <= ifdat_d;
      mdat_q  <= mdat_d;
      ifdn_q  <= ifdn_d;
      mrdn_q  <= mrdn_d;
      mwdn_q  <= mwdn_d;
      tmo_q   <= tmo_d;
    end
  end

  assign IfReadData     = ifdat_q;
  assign IfReadDone     = ifdn_q;
  assign MemReadData    = mdat_q;
  assign MemReadDone    = mrdn_q;
  assign MemWriteDone   = mwdn_q;
  assign ReadEnableOut  = ren_q;
  assign ReadAddrOut    = raddr_q;
  assign WriteEnableOut = wen_q;
  assign WriteAddrOut   = waddr_q;
  assign WriteDataOut   = wdata_q;
  assign WriteMaskOut   = wmask_q;
  assign Busy           = (state_q != IDLE);
  assign Timeout        = tmo_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter: directed transactions,
// expected issues/completions queued and checked by a negedge monitor.
module tb_axi_lite_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TMO = 255;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          IfReadReq;
  logic [AW-1:0] IfReadAddr;
  logic [DW-1:0] IfReadData;
  logic          IfReadDone;
  logic          MemReadReq;
  logic [AW-1:0] MemReadAddr;
  logic          MemWriteReq;
  logic [AW-1:0] MemWriteAddr;
  logic [DW-1:0] MemWriteData;
  logic [3:0]    MemWriteMask;
  logic [DW-1:0] MemReadData;
  logic          MemReadDone;
  logic          MemWriteDone;
  logic          ReadEnableOut;
  logic [AW-1:0] ReadAddrOut;
  logic          WriteEnableOut;
  logic [AW-1:0] WriteAddrOut;
  logic [DW-1:0] WriteDataOut;
  logic [3:0]    WriteMaskOut;
  logic [DW-1:0] ReadDataIn;
  logic          ReadDataReady;
  logic          WriteDataOver;
  logic          Busy;
  logic          Timeout;

  axi_lite_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TMO)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .IfReadReq     (IfReadReq),
    .IfReadAddr    (IfReadAddr),
    .IfReadData    (IfReadData),
    .IfReadDone    (IfReadDone),
    .MemReadReq    (MemReadReq),
    .MemReadAddr   (MemReadAddr),
    .MemWriteReq   (MemWriteReq),
    .MemWriteAddr  (MemWriteAddr),
    .MemWriteData  (MemWriteData),
    .MemWriteMask  (MemWriteMask),
    .MemReadData   (MemReadData),
    .MemReadDone   (MemReadDone),
    .MemWriteDone  (MemWriteDone),
    .ReadEnableOut (ReadEnableOut),
    .ReadAddrOut   (ReadAddrOut),
    .WriteEnableOut(WriteEnableOut),
    .WriteAddrOut  (WriteAddrOut),
    .WriteDataOut  (WriteDataOut),
    .WriteMaskOut  (WriteMaskOut),
    .ReadDataIn    (ReadDataIn),
    .ReadDataReady (ReadDataReady),
    .WriteDataOver (WriteDataOver),
    .Busy          (Busy),
    .Timeout       (Timeout)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    mask;
  } iss_t;

  // kind: 0 = IF read, 1 = MEM read, 2 = MEM write
  typedef struct {
    int            kind;
    logic [DW-1:0] data;
    bit            tmo;
  } dn_t;

  iss_t iss_q[$];
  dn_t  dn_q[$];

  int errs = 0;
  int checks = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_iss(bit wr, logic [AW-1:0] a,
                          logic [DW-1:0] d, logic [3:0] m);
    iss_t e;
    e.wr = wr; e.addr = a; e.data = d; e.mask = m;
    iss_q.push_back(e);
  endtask

  task automatic push_dn(int k, logic [DW-1:0] d, bit t);
    dn_t e;
    e.kind = k; e.data = d; e.tmo = t;
    dn_q.push_back(e);
  endtask

  // Monitor: compares every enable pulse and every completion pulse.
  always @(negedge ACLK) begin
    iss_t ie;
    dn_t  de;
    int   nd;
    int   k;
    if (ReadEnableOut || WriteEnableOut) begin
      if (iss_q.size() == 0) begin
        chk("unexpected_enable", {62'd0, WriteEnableOut, ReadEnableOut}, 64'd0);
      end else begin
        ie = iss_q.pop_front();
        chk("iss_kind", {63'd0, WriteEnableOut}, {63'd0, ie.wr});
        chk("iss_both_en", {63'd0, ReadEnableOut & WriteEnableOut}, 64'd0);
        if (ie.wr) begin
          chk("iss_waddr", WriteAddrOut, ie.addr);
          chk("iss_wdata", WriteDataOut, ie.data);
          chk("iss_wmask", {60'd0, WriteMaskOut}, {60'd0, ie.mask});
        end else begin
          chk("iss_raddr", ReadAddrOut, ie.addr);
        end
      end
    end
    nd = int'(IfReadDone) + int'(MemReadDone) + int'(MemWriteDone);
    if (nd > 0) begin
      k = IfReadDone ? 0 : (MemReadDone ? 1 : 2);
      if (dn_q.size() == 0) begin
        chk("unexpected_done", 64'(nd), 64'd0);
      end else begin
        de = dn_q.pop_front();
        chk("dn_count", 64'(nd), 64'd1);
        chk("dn_kind", 64'(k), 64'(de.kind));
        if (k == 0) chk("dn_ifdata", IfReadData, de.data);
        if (k == 1) chk("dn_memdata", MemReadData, de.data);
        chk("dn_timeout", {63'd0, Timeout}, {63'd0, de.tmo});
      end
    end else if (Timeout) begin
      chk("timeout_without_done", {63'd0, Timeout}, 64'd0);
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic wait_enable();
    int k;
    for (k = 0; k < 10; k++) begin
      cyc(1);
      if (ReadEnableOut || WriteEnableOut) break;
    end
    chk("grant_wait", {63'd0, k < 10}, 64'd1);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, {63'd0, Busy}, 64'd0);
    chk({tag, "_ren"}, {63'd0, ReadEnableOut}, 64'd0);
    chk({tag, "_wen"}, {63'd0, WriteEnableOut}, 64'd0);
    chk({tag, "_dones"},
        {61'd0, IfReadDone, MemReadDone, MemWriteDone}, 64'd0);
    chk({tag, "_tmo"}, {63'd0, Timeout}, 64'd0);
    chk({tag, "_raddr"}, ReadAddrOut, 64'd0);
    chk({tag, "_waddr"}, WriteAddrOut, 64'd0);
    chk({tag, "_wdata"}, WriteDataOut, 64'd0);
    chk({tag, "_wmask"}, {60'd0, WriteMaskOut}, 64'd0);
    chk({tag, "_ifdata"}, IfReadData, 64'd0);
    chk({tag, "_memdata"}, MemReadData, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] rr_d[4];
    rr_d[0] = 64'h1111;
    rr_d[1] = 64'h2222;
    rr_d[2] = 64'h3333;
    rr_d[3] = 64'h4444;

    ARESET = 1'b1;
    IfReadReq = 1'b0;
    IfReadAddr = '0;
    MemReadReq = 1'b0;
    MemReadAddr = '0;
    MemWriteReq = 1'b0;
    MemWriteAddr = '0;
    MemWriteData = '0;
    MemWriteMask = '0;
    ReadDataIn = '0;
    ReadDataReady = 1'b0;
    WriteDataOver = 1'b0;
    cyc(3);
    chk_zero("rst");
    ARESET = 1'b0;
    cyc(1);

    // Both request after reset: IF, MEM, IF, MEM.
    push_iss(0, 64'hA000, '0, '0);
    push_iss(0, 64'hB000, '0, '0);
    push_iss(0, 64'hA000, '0, '0);
    push_iss(0, 64'hB000, '0, '0);
    push_dn(0, rr_d[0], 0);
    push_dn(1, rr_d[1], 0);
    push_dn(0, rr_d[2], 0);
    push_dn(1, rr_d[3], 0);
    IfReadReq = 1'b1;
    IfReadAddr = 64'hA000;
    MemReadReq = 1'b1;
    MemReadAddr = 64'hB000;
    for (int i = 0; i < 4; i++) begin
      wait_enable();
      cyc(1);
      ReadDataIn = rr_d[i];
      ReadDataReady = 1'b1;
      cyc(1);
      ReadDataReady = 1'b0;
      if (i == 3) begin
        IfReadReq = 1'b0;
        MemReadReq = 1'b0;
      end
    end
    cyc(2);

    // Lone IF read, request dropped right after the grant.
    push_iss(0, 64'h8000_0000, '0, '0);
    push_dn(0, 64'h1234, 0);
    IfReadReq = 1'b1;
    IfReadAddr = 64'h8000_0000;
    wait_enable();
    IfReadReq = 1'b0;
    cyc(2);
    chk("if_busy_held", {63'd0, Busy}, 64'd1);
    ReadDataIn = 64'h1234;
    ReadDataReady = 1'b1;
    cyc(1);
    ReadDataReady = 1'b0;
    chk("if_done_latency", {63'd0, IfReadDone}, 64'd1);
    chk("if_busy_drop", {63'd0, Busy}, 64'd0);
    cyc(2);

    // Write beats read within MEM; stray read strobe ignored.
    push_iss(1, 64'hC000, 64'hDEAD, 4'hF);
    push_iss(0, 64'hD000, '0, '0);
    push_dn(2, '0, 0);
    push_dn(1, 64'h5A5A, 0);
    MemWriteReq = 1'b1;
    MemWriteAddr = 64'hC000;
    MemWriteData = 64'hDEAD;
    MemWriteMask = 4'hF;
    MemReadReq = 1'b1;
    MemReadAddr = 64'hD000;
    wait_enable();
    cyc(1);
    ReadDataIn = 64'hBAD;
    ReadDataReady = 1'b1;
    cyc(1);
    ReadDataReady = 1'b0;
    chk("wr_ignores_rd_strobe", {63'd0, Busy}, 64'd1);
    WriteDataOver = 1'b1;
    cyc(1);
    WriteDataOver = 1'b0;
    MemWriteReq = 1'b0;
    chk("wr_done_latency", {63'd0, MemWriteDone}, 64'd1);
    wait_enable();
    cyc(1);
    ReadDataIn = 64'h5A5A;
    ReadDataReady = 1'b1;
    cyc(1);
    ReadDataReady = 1'b0;
    MemReadReq = 1'b0;
    cyc(2);

    // Write strobe during an IF read is ignored.
    push_iss(0, 64'h1000, '0, '0);
    push_dn(0, 64'h77, 0);
    IfReadReq = 1'b1;
    IfReadAddr = 64'h1000;
    wait_enable();
    IfReadReq = 1'b0;
    WriteDataOver = 1'b1;
    cyc(1);
    WriteDataOver = 1'b0;
    cyc(1);
    chk("if_ignores_wr_strobe", {63'd0, Busy}, 64'd1);
    ReadDataIn = 64'h77;
    ReadDataReady = 1'b1;
    cyc(1);
    ReadDataReady = 1'b0;
    chk("if_done2", {63'd0, IfReadDone}, 64'd1);
    chk("memdata_hold", MemReadData, 64'h5A5A);
    cyc(2);

    // MEM read that never completes: abort after the wait limit.
    push_iss(0, 64'h2000, '0, '0);
    push_dn(1, '0, 1);
    MemReadReq = 1'b1;
    MemReadAddr = 64'h2000;
    wait_enable();
    MemReadReq = 1'b0;
    n = 0;
    while (n < 400) begin
      cyc(1);
      n++;
      if (MemReadDone) break;
    end
    chk("tmo_latency", 64'(n), 64'(TMO + 1));
    chk("tmo_pulse", {63'd0, Timeout}, 64'd1);
    chk("tmo_busy_drop", {63'd0, Busy}, 64'd0);
    cyc(1);
    chk("tmo_one_cycle", {63'd0, Timeout}, 64'd0);
    cyc(1);

    // Strobe in the very cycle the counter hits the limit wins.
    push_iss(0, 64'h3000, '0, '0);
    push_dn(0, 64'hABC, 0);
    IfReadReq = 1'b1;
    IfReadAddr = 64'h3000;
    wait_enable();
    IfReadReq = 1'b0;
    cyc(TMO);
    ReadDataIn = 64'hABC;
    ReadDataReady = 1'b1;
    cyc(1);
    ReadDataReady = 1'b0;
    chk("edge_done", {63'd0, IfReadDone}, 64'd1);
    chk("edge_no_tmo", {63'd0, Timeout}, 64'd0);
    cyc(2);

    // Reset three cycles into an IF read abandons it.
    push_iss(0, 64'h4000, '0, '0);
    IfReadReq = 1'b1;
    IfReadAddr = 64'h4000;
    wait_enable();
    IfReadReq = 1'b0;
    cyc(3);
    ARESET = 1'b1;
    cyc(1);
    chk_zero("midrst");
    ARESET = 1'b0;
    cyc(1);
    ReadDataIn = 64'h999;
    ReadDataReady = 1'b1;
    cyc(1);
    ReadDataReady = 1'b0;
    cyc(3);
    chk("post_rst_ifdata", IfReadData, 64'd0);
    chk("post_rst_busy", {63'd0, Busy}, 64'd0);

    chk("iss_queue_empty", 64'(iss_q.size()), 64'd0);
    chk("dn_queue_empty", 64'(dn_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
